// File: rtl/udp_egress_arbiter.sv
// Round-robin egress arbiter: grants one packet-processor lane at a time to the
// shared W5500 driver path and forwards that lane's packet word by word.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no owner; pick the next requester after rr_ptr
// ST_XFER     | forwarding words from the granted lane, idle timer running
// ST_FLUSH    | packet ended or aborted; raise flush on the next cycle
// ST_WAIT_AVAIL | hold ownership until the driver is available again
module udp_egress_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ-1:0]            i_last,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic                          i_eth_available,
  output logic [DATA_WIDTH-1:0]         o_eth_data,
  output logic                          o_eth_valid,
  output logic                          o_eth_flush,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic [7:0]                    o_abort_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   IDLE_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_FLUSH,
    ST_WAIT_AVAIL
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [CNT_W-1:0]      idle_cnt;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;

  // Descending scan so the candidate closest after rr_ptr is written last and wins.
  always_comb begin
    int cand;
    cand       = 0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (i_req[cand]) begin
        pick_idx   = IDX_W'(cand);
        pick_valid = 1'b1;
      end
    end
  end

  assign sel_valid = i_valid[grant_idx];
  assign sel_last  = i_last[grant_idx];
  assign sel_data  = i_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign xfer      = (state == ST_XFER) && sel_valid && i_eth_available;
  assign o_ready   = ((state == ST_XFER) && i_eth_available) ? o_grant : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= PTR_RST;
      grant_idx   <= '0;
      idle_cnt    <= '0;
      o_grant     <= '0;
      o_eth_data  <= '0;
      o_eth_valid <= 1'b0;
      o_eth_flush <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_abort_cnt <= '0;
    end else begin
      o_eth_valid <= 1'b0;
      o_eth_flush <= 1'b0;
      o_timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            o_grant   <= ONE_HOT0 << pick_idx;
            grant_idx <= pick_idx;
            idle_cnt  <= '0;
            o_busy    <= 1'b1;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A word accepted on the threshold cycle takes precedence over the abort.
          if (xfer) begin
            o_eth_data  <= sel_data;
            o_eth_valid <= 1'b1;
            idle_cnt    <= '0;
            if (sel_last) state <= ST_FLUSH;
          end else if (idle_cnt == IDLE_MAX) begin
            o_timeout <= 1'b1;
            if (o_abort_cnt != 8'hFF) o_abort_cnt <= o_abort_cnt + 8'd1;
            state <= ST_FLUSH;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          o_eth_flush <= 1'b1;
          state       <= ST_WAIT_AVAIL;
        end
        ST_WAIT_AVAIL: begin
          if (i_eth_available) begin
            rr_ptr  <= grant_idx;
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/udp_egress_arbiter.md
Name: udp_egress_arbiter

Overview:
Round-robin scheduler that shares the single W5500 driver egress path between NUM_REQ packet-processor lanes.
- Each lane presents checksum-verified packets as a 16-bit word stream with valid/ready/last.
- The arbiter grants one lane for a whole packet; packets are never interleaved.
- Words are forwarded only while the driver reports available. One flush pulse is issued per packet.
- Sits between the per-lane packet processors and the W5500 driver instance.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- DATA_WIDTH, 16, word width of lane and driver data.
- TIMEOUT_CYCLES, 1024, max idle cycles inside a granted packet before abort (>=2).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req  in  NUM_REQ  lane has a complete verified packet pending.
- i_data  in  NUM_REQ*DATA_WIDTH  lane words; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_valid  in  NUM_REQ  lane word valid.
- i_last  in  NUM_REQ  lane word is the final word of its packet.
- o_ready  out  NUM_REQ  per-lane word accept (combinational).
- i_eth_available  in  1  driver can take data.
- o_eth_data  out  DATA_WIDTH  word to driver (registered).
- o_eth_valid  out  1  one-cycle strobe per forwarded word.
- o_eth_flush  out  1  one-cycle flush request at end of packet.
- o_grant  out  NUM_REQ  one-hot current owner; 0 when none.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  one-cycle pulse on packet abort.
- o_abort_cnt  out  8  saturating count of aborted packets.

Behaviour:
- Reset values (async on i_rst):
  - State IDLE.
  - o_grant=0, o_eth_data=0, o_eth_valid=0, o_eth_flush=0, o_busy=0, o_timeout=0, o_abort_cnt=0.
  - Round-robin pointer = NUM_REQ-1, so lane 0 has first priority.
  - Idle counter = 0.
- Reset mid-packet abandons the packet silently. It does not pulse flush or timeout and does not count as an abort.
- States: IDLE, XFER, FLUSH, WAIT_AVAIL.
- IDLE:
  - When any i_req is high, pick the first requesting lane searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Register o_grant and move to XFER.
  - Grant latency is 1 cycle from i_req. Simultaneous requests are resolved only by round-robin order.
- XFER:
  - o_ready[g] = i_eth_available for the granted lane g. o_ready of all other lanes = 0. o_ready is 0 in every other state.
  - A transfer occurs when i_valid[g] & o_ready[g]. On the next edge: o_eth_data <= lane word, o_eth_valid <= 1; otherwise o_eth_valid <= 0.
  - Word latency is 1 cycle.
  - If the transferred word has i_last[g]=1, go to FLUSH.
  - i_req[g] is ignored after the grant; dropping it does not end the packet.
  - Idle counter increments every XFER cycle without a transfer and clears on each transfer.
  - If the idle counter reaches TIMEOUT_CYCLES-1 without a transfer, abort:
    - o_timeout pulses 1 cycle.
    - o_abort_cnt increments, saturating at 255.
    - Go to FLUSH.
  - A transfer on the same cycle as the timeout threshold wins; no abort occurs.
- FLUSH:
  - o_eth_flush = 1 for exactly one cycle. This cycle immediately follows the last word's o_eth_valid cycle, so the two never overlap.
  - Next state is WAIT_AVAIL.
- WAIT_AVAIL:
  - Remain until i_eth_available=1.
  - Then set pointer <= g, o_grant <= 0, and go to IDLE.
  - The next grant is possible one cycle later. Minimum gap between packets is 2 idle cycles on the driver side.
- i_eth_available low during XFER stalls the lane (o_ready=0). Stall cycles count toward the timeout.
- Single-word packet (valid+last on the first accepted word) takes 4 cycles: XFER (transfer) -> FLUSH (flush) -> WAIT_AVAIL -> IDLE.
- The pointer updates only on packet completion or abort. A lane that keeps requesting cannot starve others.

Test Plan:
1. Single requester: lane 2 sends 3 words 0x1111, 0x2222, 0x3333 (last on the third), available=1.
   -> o_grant=4'b0100 one cycle after i_req.
   -> o_eth_valid on 3 consecutive cycles carrying 0x1111, 0x2222, 0x3333.
   -> o_eth_flush high for 1 cycle on the following cycle; o_grant returns to 0.
2. Fairness: all 4 lanes request continuously, 1-word packets each.
   -> Grant order after reset is 0, 1, 2, 3, 0.
   -> Exactly one o_eth_flush per packet; no two grants are ever set at once.
3. Backpressure: i_eth_available drops for 5 cycles mid-packet.
   -> o_ready[g]=0 and no o_eth_valid during those cycles.
   -> Words resume in order with no loss or duplication.
   -> WAIT_AVAIL holds while available=0.
4. Timeout: TIMEOUT_CYCLES=8; lane 1 is granted, sends 1 word, then holds valid=0.
   -> o_timeout pulses 8 cycles after the last transfer.
   -> o_abort_cnt=1 and o_eth_flush pulses.
   -> Lane 2 is granted next even though lane 1 still requests.
5. Async reset asserted mid-packet (after word 2 of 4).
   -> All outputs zero immediately, without waiting for a clock edge.
   -> No flush is issued.
   -> After release, lane 0 wins a simultaneous lane 0/lane 3 request.
6. Saturation: force 260 aborts.
   -> o_abort_cnt holds at 255.
